// File: rtl/conv2_frame_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv2_frame_ctrl_if : frame-control handshake bundle for conv2_frame_ctrl |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface conv2_frame_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       busy;
  logic       out_valid;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       frame_done;
  logic       err;

  modport master (
    output start, in_valid,
    input  busy, out_valid, out_row, out_col, frame_done, err
  );

  modport slave (
    input  start, in_valid,
    output busy, out_valid, out_row, out_col, frame_done, err
  );
endinterface
`default_nettype wire

// File: rtl/conv2_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv2_frame_ctrl : frame sequencer and window-valid tracker for conv2     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module conv2_frame_ctrl #(
  parameter int IMG_W    = 12,
  parameter int IMG_H    = 12,
  parameter int K        = 5,
  parameter int CALC_LAT = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  conv2_frame_ctrl_if.slave bus
);

  localparam int OW      = IMG_W - K + 1;
  localparam int OH      = IMG_H - K + 1;
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int CNT_W   = $clog2(OW * OH + 1);
  localparam int DRAIN_W = $clog2(CALC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [2:0]          r_orow;
  logic [2:0]          r_ocol;
  logic [CNT_W-1:0]    r_vcnt;
  logic [DRAIN_W-1:0]  r_drain;
  logic [CALC_LAT-1:0] r_pipe;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [2:0]          r_out_row;
  logic [2:0]          r_out_col;

  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_push;
  logic w_next_valid;

  assign w_accept   = bus.in_valid && ((r_state == S_FILL) || (r_state == S_RUN));
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_push     = w_accept && (int'(r_row) >= K - 1) && (int'(r_col) >= K - 1);

  // w_next_valid is the pipe stage that becomes out_valid on the next edge,
  // so the displayed index is loaded in step with out_valid rising.
  generate
    if (CALC_LAT == 1) begin : g_lat_one
      assign w_next_valid = w_push;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= w_push;
      end
    end else begin : g_lat_multi
      assign w_next_valid = r_pipe[CALC_LAT-2];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[CALC_LAT-2:0], w_push};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_orow    <= '0;
      r_ocol    <= '0;
      r_vcnt    <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_next_valid) begin
        r_out_row <= r_orow;
        r_out_col <= r_ocol;
        if (r_ocol == 3'(OW - 1)) begin
          r_ocol <= '0;
          r_orow <= r_orow + 3'd1;
        end else begin
          r_ocol <= r_ocol + 3'd1;
        end
      end

      if (r_pipe[CALC_LAT-1]) r_vcnt <= r_vcnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // A pixel arriving with start is dropped but still flagged.
            r_state <= S_FILL;
            r_busy  <= 1'b1;
            r_err   <= bus.in_valid;
            r_row   <= '0;
            r_col   <= '0;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_vcnt  <= '0;
          end else if (bus.in_valid) begin
            r_err <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_accept && (r_row == ROW_W'(K - 1)) && (r_col == COL_W'(K - 1)))
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept && w_row_last && w_col_last) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (bus.in_valid) r_err <= 1'b1;
          if (r_drain == DRAIN_W'(CALC_LAT - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            // The final result of the frame is still on out_valid this cycle.
            if ((r_vcnt + CNT_W'(r_pipe[CALC_LAT-1])) != CNT_W'(OW * OH))
              r_err <= 1'b1;
          end else begin
            r_drain <= r_drain + DRAIN_W'(1);
          end
        end
        S_DONE: begin
          if (bus.in_valid) r_err <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.out_valid  = r_pipe[CALC_LAT-1];
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.frame_done = r_done;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv2_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv2_frame_ctrl : randomized bench with a frame-level reference model |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_conv2_frame_ctrl;

  localparam int IMG_W = 12;
  localparam int IMG_H = 12;
  localparam int K     = 5;
  localparam int L     = 2;
  localparam int OW    = IMG_W - K + 1;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  conv2_frame_ctrl_if bus ();

  conv2_frame_ctrl #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .K        (K),
    .CALC_LAT (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: mode 0 idle, 1 taking pixels, 2 frame ended awaiting done.
  int         mode      = 0;
  int         pix       = 0;
  int         idx       = 0;
  int         done_cyc  = -1;
  int         busy_from = 1 << 30;
  int         busy_to   = -1;
  logic       exp_err   = 1'b0;
  logic [2:0] last_row  = '0;
  logic [2:0] last_col  = '0;
  logic [5:0] exp_at [int];
  logic       mon_ev;
  logic [5:0] mon_rc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mode      = 0;
    exp_at.delete();
    done_cyc  = -1;
    busy_from = 1 << 30;
    busy_to   = -1;
    last_row  = '0;
    last_col  = '0;
    exp_err   = 1'b0;
  endtask

  // One clock cycle of stimulus; the model predicts what it causes.
  task automatic step(input bit st, input bit iv);
    int n;
    int r;
    int c;
    n = cyc;
    if (mode == 2 && n > done_cyc) mode = 0;
    bus.start    = st;
    bus.in_valid = iv;
    if (iv && mode == 1) begin
      r = pix / IMG_W;
      c = pix % IMG_W;
      if (r >= K - 1 && c >= K - 1) begin
        exp_at[n + L] = {3'(idx / OW), 3'(idx % OW)};
        idx++;
      end
      pix++;
      if (pix == NPIX) begin
        mode     = 2;
        done_cyc = n + L + 1;
        busy_to  = done_cyc;
      end
    end else if (iv) begin
      exp_err = 1'b1;
    end
    if (st && mode == 0) begin
      mode      = 1;
      pix       = 0;
      idx       = 0;
      exp_err   = iv;
      busy_from = n + 1;
      busy_to   = 1 << 30;
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit st_iv, input int max_gap, input bit spam,
                           input int npix, input bit drain_pix);
    int gap;
    step(1'b1, st_iv);
    check("err_at_start", bus.err, exp_err);
    for (int p = 0; p < npix; p++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) step(spam && ($urandom_range(1, 0) == 1), 1'b0);
      step(spam && ($urandom_range(1, 0) == 1), 1'b1);
    end
    if (npix == NPIX) begin
      if (drain_pix) step(1'b0, 1'b1);
      repeat (L + 3) step(1'b0, 1'b0);
      check("frame_err", bus.err, exp_err);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_ev = exp_at.exists(cyc);
      check("out_valid", bus.out_valid, mon_ev);
      if (mon_ev) begin
        mon_rc   = exp_at[cyc];
        last_row = mon_rc[5:3];
        last_col = mon_rc[2:0];
        exp_at.delete(cyc);
      end
      check("out_row", bus.out_row, last_row);
      check("out_col", bus.out_col, last_col);
      check("frame_done", bus.frame_done, cyc == done_cyc);
      check("busy", bus.busy, (cyc >= busy_from) && (cyc <= busy_to));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  bus.busy,       1'b0);
    check({tag, "_valid"}, bus.out_valid,  1'b0);
    check({tag, "_row"},   bus.out_row,    3'd0);
    check({tag, "_col"},   bus.out_col,    3'd0);
    check({tag, "_done"},  bus.frame_done, 1'b0);
    check({tag, "_err"},   bus.err,        1'b0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Nominal back-to-back frame, then a gapped one.
    run_frame(1'b0, 0, 1'b0, NPIX, 1'b0);
    run_frame(1'b0, 3, 1'b0, NPIX, 1'b0);

    // Stray pixel in idle, cleared by the next start.
    step(1'b0, 1'b1);
    check("err_idle_pix", bus.err, exp_err);
    run_frame(1'b0, 1, 1'b0, NPIX, 1'b0);

    // Start and pixel together, then a pixel during drain.
    run_frame(1'b1, 0, 1'b0, NPIX, 1'b0);
    run_frame(1'b0, 0, 1'b0, NPIX, 1'b1);

    // Start pulses while running must be ignored.
    run_frame(1'b0, 2, 1'b1, NPIX, 1'b0);

    // Reset mid-frame, then a fresh clean frame.
    run_frame(1'b0, 1, 1'b0, 70, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    run_frame(1'b0, 0, 1'b0, NPIX, 1'b0);
    check("leftover_results", exp_at.num(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2_frame_ctrl.md
CONV2_FRAME_CTRL -- requirements
Module: conv2_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 12, input feature-map width in pixels.
REQ-002 SHALL have parameter IMG_H, default 12, input feature-map height in pixels.
REQ-003 SHALL have parameter K, default 5, convolution kernel size; OW = IMG_W-K+1 and OH = IMG_H-K+1 (8 and 8 at defaults).
REQ-004 SHALL have parameter CALC_LAT, default 2 (legal range 1..8), cycles from an accepted pixel to the matching convolution result.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, one-cycle frame-start request.
REQ-008 SHALL have port in_valid, input, 1 bit, pooled pixel present on all three channels this cycle.
REQ-009 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 SHALL have port out_valid, output, 1 bit, current convolution result is a legal window position.
REQ-011 SHALL have port out_row, output, 3 bits, output row index 0..OH-1 of the current out_valid result.
REQ-012 SHALL have port out_col, output, 3 bits, output column index 0..OW-1 of the current out_valid result.
REQ-013 SHALL have port frame_done, output, 1 bit, one-cycle pulse at frame end.
REQ-014 SHALL have port err, output, 1 bit, sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, RUN, DRAIN, DONE.
REQ-016 SHALL move IDLE->FILL on start; start in any other state SHALL be ignored.
REQ-017 SHALL accept a pixel only when in_valid=1 in FILL or RUN; accepted pixels advance col (0..IMG_W-1) and, at col wrap, row (0..IMG_H-1).
REQ-018 SHALL move FILL->RUN on acceptance of pixel (row K-1, col K-1).
REQ-019 SHALL move RUN->DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-020 SHALL mark an accepted pixel as window-valid iff row>=K-1 and col>=K-1, and push that mark through a CALC_LAT-deep shift register; out_valid is the register output.
REQ-021 SHALL ensure non-accepted cycles (including in_valid gaps) push 0 into the shift register, so out_valid never fires on stalled cycles.
REQ-022 SHALL present out_row/out_col as an output counter: col increments on each out_valid, wraps at OW-1 with row increment; the counter clears on entry to FILL.
REQ-023 SHALL leave DRAIN after exactly CALC_LAT cycles, entering DONE.
REQ-024 SHALL assert frame_done for the single DONE cycle, then return to IDLE.
REQ-025 SHALL set err if, at DONE, the count of out_valid pulses in the frame is not OH*OW (64).
REQ-026 SHALL set err on in_valid=1 in IDLE, DRAIN or DONE; such pixels are dropped and no counter changes.
REQ-027 SHALL treat start and in_valid in the same IDLE cycle as: transition to FILL, pixel dropped, err set.
REQ-028 SHALL clear err only on reset or on an accepted start (IDLE->FILL), except as required by REQ-027.
REQ-029 SHALL hold out_row/out_col at last values when out_valid=0.

Reset
REQ-030 SHALL, on rst=1 at any time (including mid-frame), immediately force state IDLE, all counters and shift register to 0, and busy, out_valid, out_row, out_col, frame_done and err to 0.
REQ-031 SHALL require a new start after rst deasserts; no partial-frame output resumes.

Verification
REQ-032 Nominal: start, then 144 back-to-back in_valid -> 64 out_valid pulses, first (0,0) at CALC_LAT cycles after pixel 52 (row 4, col 4), last (7,7); frame_done one cycle CALC_LAT+1 cycles after pixel 143; err=0.
REQ-033 Gapped: 144 pixels with random 0-3 idle cycles between them -> same 64 (row,col) sequence, out_valid never on gap-derived cycles, err=0.
REQ-034 Column mask: observe pixels at col 0..3 of rows 4..11 -> no out_valid CALC_LAT cycles later; col 4..11 -> out_valid.
REQ-035 Protocol error: in_valid in IDLE, then start -> err=1 then cleared on start; start+in_valid same cycle -> err=1, FILL entered.
REQ-036 Reset mid-frame: rst after 70 pixels -> all outputs 0 the same cycle; fresh start and 144 pixels -> clean 64-result frame.
REQ-037 Ignored start: start pulses during RUN -> no state or counter disturbance, frame completes normally.
